inst_rom_loader: RTL and testbench

Instruction-memory responder for the openmips fetch port: accepts the core's `rom_ce_o`/`rom_addr_o` and returns `rom_data_i`. Before fetch is enabled, the program is written in through a byte-serial load port, e.g. from a UART or the testbench. The block then serves words combinationally, so the core's fetch stage needs no changes.

---
 rtl/inst_rom_loader.sv | 138 +++++++++++++
 tb/tb_inst_rom_loader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_loader.sv
// Instruction ROM for the openmips fetch port. A byte-serial loader fills the
// memory with a program, and fetches are then served combinationally.
module inst_rom_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid_i,
    input  logic [7:0]        ld_byte_i,
    output logic              ld_ready_o,
    input  logic              ld_done_i,
    input  logic              rom_ce_i,
    input  logic [31:0]       rom_addr_i,
    output logic [31:0]       rom_data_o,
    output logic              rom_ready_o,
    output logic [ADDR_W:0]   words_o,
    output logic              ovf_o
);

    localparam int              DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_W = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic {LOAD, RUN} state_e;

    state_e          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [31:0]     asm_q, asm_d;
    logic [ADDR_W:0] words_q, words_d;
    logic            ovf_q, ovf_d;
    logic            ready_q, ready_d;
    logic            rom_ready_q, rom_ready_d;

    logic            accept;
    logic [1:0]      cnt_acc;
    logic [31:0]     asm_acc;
    logic            wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]     wr_data;

    logic [31:0]     mem [DEPTH];

    logic [ADDR_W-1:0] fetch_idx;
    logic              fetch_hit;
    logic              unused_addr_bits;

    // asm_acc/cnt_acc include this cycle's byte, so a done pulse arriving
    // alongside a byte finalises the word with that byte already placed.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        words_d  = words_q;
        ovf_d    = ovf_q;
        wr_en    = 1'b0;
        wr_addr  = words_q[ADDR_W-1:0];
        accept   = (state_q == LOAD) && ld_valid_i && ready_q;
        asm_acc  = asm_q;
        cnt_acc  = cnt_q;

        if (accept) begin
            asm_acc = asm_q | ({24'h0, ld_byte_i} << {~cnt_q, 3'b000});
            cnt_acc = cnt_q + 2'd1;
        end
        wr_data = asm_acc;

        if (state_q == LOAD) begin
            if (ld_valid_i && !ready_q) begin
                ovf_d = 1'b1;
            end

            if (accept && (cnt_q == 2'd3)) begin
                wr_en   = 1'b1;
                words_d = words_q + ONE_W;
                asm_d   = 32'h0;
                cnt_d   = 2'd0;
            end else if (accept) begin
                asm_d = asm_acc;
                cnt_d = cnt_acc;
            end

            if (ld_done_i) begin
                state_d = RUN;
                cnt_d   = 2'd0;
                asm_d   = 32'h0;
                if (cnt_acc != 2'd0) begin
                    if (words_q < FULL) begin
                        wr_en   = 1'b1;
                        words_d = words_q + ONE_W;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
        end

        ready_d     = (state_d == LOAD) && (words_d < FULL);
        rom_ready_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= LOAD;
            cnt_q       <= 2'd0;
            asm_q       <= 32'h0;
            words_q     <= '0;
            ovf_q       <= 1'b0;
            ready_q     <= 1'b1;
            rom_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            words_q     <= words_d;
            ovf_q       <= ovf_d;
            ready_q     <= ready_d;
            rom_ready_q <= rom_ready_d;
        end
    end

    // Storage is left unreset; the words_q bound on fetch hides stale contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign fetch_idx        = rom_addr_i[ADDR_W+1:2];
    assign unused_addr_bits = ^{rom_addr_i[31:ADDR_W+2], rom_addr_i[1:0]};
    assign fetch_hit        = rom_ce_i && (state_q == RUN) && ({1'b0, fetch_idx} < words_q);
    assign rom_data_o       = fetch_hit ? mem[fetch_idx] : 32'h0;

    assign ld_ready_o  = ready_q;
    assign rom_ready_o = rom_ready_q;
    assign words_o     = words_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader using a 4-word memory so the full and
// overflow paths are reached quickly.
module tb_inst_rom_loader;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          ldValid;
    logic [7:0]    ldByte;
    logic          ldReady;
    logic          ldDone;
    logic          romCe;
    logic [31:0]   romAddr;
    logic [31:0]   romData;
    logic          romReady;
    logic [AW:0]   wordsO;
    logic          ovfO;

    int checks = 0;
    int errors = 0;

    inst_rom_loader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_valid_i (ldValid),
        .ld_byte_i  (ldByte),
        .ld_ready_o (ldReady),
        .ld_done_i  (ldDone),
        .rom_ce_i   (romCe),
        .rom_addr_i (romAddr),
        .rom_data_o (romData),
        .rom_ready_o(romReady),
        .words_o    (wordsO),
        .ovf_o      (ovfO)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle of load-port activity, driven at negedge and released after the edge.
    task automatic applyStimulus(input logic valid, input logic [7:0] b, input logic done);
        @(negedge clk);
        ldValid = valid;
        ldByte  = b;
        ldDone  = done;
        @(posedge clk);
        #1;
        ldValid = 1'b0;
        ldByte  = 8'h00;
        ldDone  = 1'b0;
    endtask

    task automatic fetchCheck(input string tag, input logic ce, input logic [31:0] addr,
                              input logic [31:0] exp);
        romCe   = ce;
        romAddr = addr;
        #1;
        checkOutput(tag, romData, exp);
    endtask

    task automatic doReset();
        ldValid = 1'b0;
        ldDone  = 1'b0;
        romCe   = 1'b0;
        rst     = 1'b0;
        #3;
        rst     = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b0;
        ldValid = 1'b0;
        ldByte  = 8'h00;
        ldDone  = 1'b0;
        romCe   = 1'b1;
        romAddr = 32'h0;
        #12;
        rst = 1'b1;
        @(posedge clk);
        #1;

        checkOutput("rst_ld_ready", {31'b0, ldReady}, 32'h1);
        checkOutput("rst_rom_ready", {31'b0, romReady}, 32'h0);
        checkOutput("rst_words", {29'b0, wordsO}, 32'h0);
        checkOutput("rst_ovf", {31'b0, ovfO}, 32'h0);
        fetchCheck("rst_data", 1'b1, 32'h0, 32'h0);

        // Two full words, then a standalone done pulse.
        applyStimulus(1'b1, 8'h34, 1'b0);
        applyStimulus(1'b1, 8'h01, 1'b0);
        applyStimulus(1'b1, 8'h11, 1'b0);
        applyStimulus(1'b1, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'h34, 1'b0);
        applyStimulus(1'b1, 8'h02, 1'b0);
        applyStimulus(1'b1, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'h20, 1'b0);
        checkOutput("t1_words_pre", {29'b0, wordsO}, 32'h2);
        checkOutput("t1_rom_ready_pre", {31'b0, romReady}, 32'h0);
        fetchCheck("t1_load_nop", 1'b1, 32'h0, 32'h0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t1_rom_ready", {31'b0, romReady}, 32'h1);
        checkOutput("t1_words", {29'b0, wordsO}, 32'h2);
        checkOutput("t1_ld_ready", {31'b0, ldReady}, 32'h0);
        fetchCheck("t1_addr0", 1'b1, 32'h0, 32'h34011100);
        fetchCheck("t1_addr4", 1'b1, 32'h4, 32'h34020020);
        fetchCheck("t1_addr8", 1'b1, 32'h8, 32'h0);
        fetchCheck("t1_addr5", 1'b1, 32'h5, 32'h34020020);
        fetchCheck("t1_alias10", 1'b1, 32'h10, 32'h34011100);
        fetchCheck("t1_ce0", 1'b0, 32'h4, 32'h0);

        // Load port must be ignored in RUN.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 8'hFF, (i == 3));
        end
        checkOutput("run_ld_ready", {31'b0, ldReady}, 32'h0);
        checkOutput("run_words", {29'b0, wordsO}, 32'h2);
        checkOutput("run_ovf", {31'b0, ovfO}, 32'h0);
        fetchCheck("run_addr0", 1'b1, 32'h0, 32'h34011100);
        fetchCheck("run_addr4", 1'b1, 32'h4, 32'h34020020);
        fetchCheck("run_addr8", 1'b1, 32'h8, 32'h0);

        // Done coincident with the 6th byte pads the partial word.
        doReset();
        checkOutput("t2_rom_ready_rst", {31'b0, romReady}, 32'h0);
        applyStimulus(1'b1, 8'hAA, 1'b0);
        applyStimulus(1'b1, 8'hBB, 1'b0);
        applyStimulus(1'b1, 8'hCC, 1'b0);
        applyStimulus(1'b1, 8'hDD, 1'b0);
        applyStimulus(1'b1, 8'hEE, 1'b0);
        applyStimulus(1'b1, 8'hFF, 1'b1);
        checkOutput("t2_words", {29'b0, wordsO}, 32'h2);
        checkOutput("t2_rom_ready", {31'b0, romReady}, 32'h1);
        fetchCheck("t2_word0", 1'b1, 32'h0, 32'hAABBCCDD);
        fetchCheck("t2_word1", 1'b1, 32'h4, 32'hEEFF0000);

        // Three bytes then a separate done.
        doReset();
        applyStimulus(1'b1, 8'h11, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0);
        applyStimulus(1'b1, 8'h33, 1'b0);
        checkOutput("t3_words_pre", {29'b0, wordsO}, 32'h0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t3_words", {29'b0, wordsO}, 32'h1);
        fetchCheck("t3_word0", 1'b1, 32'h0, 32'h11223300);

        // Fill all four words, then one more byte overflows.
        doReset();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0);
        end
        checkOutput("t4_words_full", {29'b0, wordsO}, 32'h4);
        checkOutput("t4_ld_ready_full", {31'b0, ldReady}, 32'h0);
        checkOutput("t4_ovf_pre", {31'b0, ovfO}, 32'h0);
        applyStimulus(1'b1, 8'h10, 1'b0);
        checkOutput("t4_ovf", {31'b0, ovfO}, 32'h1);
        checkOutput("t4_words_ovf", {29'b0, wordsO}, 32'h4);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t4_rom_ready", {31'b0, romReady}, 32'h1);
        checkOutput("t4_words_run", {29'b0, wordsO}, 32'h4);
        fetchCheck("t4_word0", 1'b1, 32'h0, 32'h00010203);
        fetchCheck("t4_word3", 1'b1, 32'hC, 32'h0C0D0E0F);

        // Asynchronous reset mid-load discards everything.
        doReset();
        applyStimulus(1'b1, 8'h99, 1'b0);
        applyStimulus(1'b1, 8'h88, 1'b0);
        applyStimulus(1'b1, 8'h77, 1'b0);
        applyStimulus(1'b1, 8'h66, 1'b0);
        applyStimulus(1'b1, 8'h55, 1'b0);
        applyStimulus(1'b1, 8'h44, 1'b0);
        checkOutput("t5_words_pre", {29'b0, wordsO}, 32'h1);
        rst = 1'b0;
        #2;
        checkOutput("t5_words_async", {29'b0, wordsO}, 32'h0);
        checkOutput("t5_ld_ready_async", {31'b0, ldReady}, 32'h1);
        rst = 1'b1;
        applyStimulus(1'b1, 8'h12, 1'b0);
        applyStimulus(1'b1, 8'h34, 1'b0);
        applyStimulus(1'b1, 8'h56, 1'b0);
        applyStimulus(1'b1, 8'h78, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t5_words", {29'b0, wordsO}, 32'h1);
        fetchCheck("t5_word0", 1'b1, 32'h0, 32'h12345678);
        fetchCheck("t5_addr4", 1'b1, 32'h4, 32'h0);

        // Done with nothing loaded.
        doReset();
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t6_rom_ready", {31'b0, romReady}, 32'h1);
        checkOutput("t6_words", {29'b0, wordsO}, 32'h0);
        fetchCheck("t6_addr0", 1'b1, 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
